// File: rtl/vga_pattern_gen_if.sv
// Pixel-stage bundle: timing-counter inputs, user controls and registered RGB/sync/mode outputs.
interface vga_pattern_gen_if;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        active_in;
  logic        hsync_in;
  logic        vsync_in;
  logic        mode_step;
  logic        force_white;
  logic        red_out;
  logic        green_out;
  logic        blue_out;
  logic        hsync_out;
  logic        vsync_out;
  logic [1:0]  mode;

  modport master (
    output hcount, vcount, active_in, hsync_in, vsync_in, mode_step, force_white,
    input  red_out, green_out, blue_out, hsync_out, vsync_out, mode
  );

  modport slave (
    input  hcount, vcount, active_in, hsync_in, vsync_in, mode_step, force_white,
    output red_out, green_out, blue_out, hsync_out, vsync_out, mode
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern colour stage: bars, checker, bouncing box and cycling solid colour,
// with mode changes deferred to the next frame boundary and sync delayed to match RGB.
module vga_pattern_gen #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned V_ACTIVE  = 600,
  parameter int unsigned BAR_W     = 100,
  parameter int unsigned BOX_SIZE  = 64,
  parameter int unsigned STEP      = 4,
  parameter int unsigned SOLID_DIV = 64
) (
  input logic               clk,
  input logic               rst_n,
  vga_pattern_gen_if.slave  vif
);

  localparam int unsigned XW = 11;
  localparam int unsigned YW = 10;
  localparam int unsigned FW = (SOLID_DIV > 1) ? $clog2(SOLID_DIV) : 1;

  localparam logic [XW-1:0] X_MAX   = XW'(H_ACTIVE - BOX_SIZE);
  localparam logic [YW-1:0] Y_MAX   = YW'(V_ACTIVE - BOX_SIZE);
  localparam logic [XW-1:0] X_STEP  = XW'(STEP);
  localparam logic [YW-1:0] Y_STEP  = YW'(STEP);
  localparam logic [XW-1:0] X_BOX   = XW'(BOX_SIZE);
  localparam logic [YW-1:0] Y_BOX   = YW'(BOX_SIZE);
  localparam logic [FW-1:0] CNT_TOP = FW'(SOLID_DIV - 1);

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_BOX   = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  mode_e         mode_q, mode_d;
  logic          pending_q, pending_d;
  logic          vs_q;
  logic [XW-1:0] box_x_q, box_x_d;
  logic [YW-1:0] box_y_q, box_y_d;
  logic          dx_neg_q, dx_neg_d;
  logic          dy_neg_q, dy_neg_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]    solid_col_q, solid_col_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          hs_out_q, vs_out_q;

  logic          frame_tick_c;
  logic [2:0]    bar_idx_c;
  logic          in_box_c;
  logic [2:0]    pattern_c;

  // Frame-rate state: mode application, box motion and solid-colour cycling.
  always_comb begin
    mode_d      = mode_q;
    pending_d   = pending_q | vif.mode_step;
    box_x_d     = box_x_q;
    box_y_d     = box_y_q;
    dx_neg_d    = dx_neg_q;
    dy_neg_d    = dy_neg_q;
    frame_cnt_d = frame_cnt_q;
    solid_col_d = solid_col_q;

    frame_tick_c = vif.vsync_in & ~vs_q;

    if (frame_tick_c) begin
      if (pending_q | vif.mode_step) begin
        mode_d = mode_e'(2'(mode_q + 2'd1));
      end
      pending_d = 1'b0;

      if (!dx_neg_q) begin
        if ((box_x_q + X_STEP) > X_MAX) begin
          box_x_d  = X_MAX;
          dx_neg_d = 1'b1;
        end else begin
          box_x_d = box_x_q + X_STEP;
        end
      end else if (box_x_q < X_STEP) begin
        box_x_d  = '0;
        dx_neg_d = 1'b0;
      end else begin
        box_x_d = box_x_q - X_STEP;
      end

      if (!dy_neg_q) begin
        if ((box_y_q + Y_STEP) > Y_MAX) begin
          box_y_d  = Y_MAX;
          dy_neg_d = 1'b1;
        end else begin
          box_y_d = box_y_q + Y_STEP;
        end
      end else if (box_y_q < Y_STEP) begin
        box_y_d  = '0;
        dy_neg_d = 1'b0;
      end else begin
        box_y_d = box_y_q - Y_STEP;
      end

      // Solid colour steps through 1..7, never black.
      if (frame_cnt_q == CNT_TOP) begin
        frame_cnt_d = '0;
        solid_col_d = (solid_col_q == 3'd7) ? 3'd1 : 3'(solid_col_q + 3'd1);
      end else begin
        frame_cnt_d = FW'(frame_cnt_q + FW'(1));
      end
    end
  end

  // Per-pixel colour from the current inputs and state.
  always_comb begin
    bar_idx_c = 3'd0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (vif.hcount >= XW'(k * BAR_W)) begin
        bar_idx_c = 3'(bar_idx_c + 3'd1);
      end
    end

    in_box_c = (vif.hcount >= box_x_q) && (vif.hcount < (box_x_q + X_BOX)) &&
               (vif.vcount >= box_y_q) && (vif.vcount < (box_y_q + Y_BOX));

    pattern_c = 3'b000;
    case (mode_q)
      MODE_BARS:  pattern_c = bar_idx_c;
      MODE_CHECK: pattern_c = (vif.hcount[5] ^ vif.vcount[5]) ? 3'b111 : 3'b000;
      MODE_BOX:   pattern_c = in_box_c ? 3'b111 : 3'b001;
      MODE_SOLID: pattern_c = solid_col_q;
      default:    pattern_c = 3'b000;
    endcase

    rgb_d = 3'b000;
    if (vif.active_in) begin
      rgb_d = vif.force_white ? 3'b111 : pattern_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q      <= MODE_BARS;
      pending_q   <= 1'b0;
      vs_q        <= 1'b0;
      box_x_q     <= '0;
      box_y_q     <= '0;
      dx_neg_q    <= 1'b0;
      dy_neg_q    <= 1'b0;
      frame_cnt_q <= '0;
      solid_col_q <= 3'b001;
      rgb_q       <= 3'b000;
      hs_out_q    <= 1'b0;
      vs_out_q    <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      pending_q   <= pending_d;
      vs_q        <= vif.vsync_in;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      dx_neg_q    <= dx_neg_d;
      dy_neg_q    <= dy_neg_d;
      frame_cnt_q <= frame_cnt_d;
      solid_col_q <= solid_col_d;
      rgb_q       <= rgb_d;
      hs_out_q    <= vif.hsync_in;
      vs_out_q    <= vif.vsync_in;
    end
  end

  assign vif.red_out   = rgb_q[2];
  assign vif.green_out = rgb_q[1];
  assign vif.blue_out  = rgb_q[0];
  assign vif.hsync_out = hs_out_q;
  assign vif.vsync_out = vs_out_q;
  assign vif.mode      = mode_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: bars, mode stepping, checker, box bounce, solid cycling,
// force-white, sync delay and synchronous reset behaviour.
module tb_vga_pattern_gen;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   ticks;

  vga_pattern_gen_if vif ();

  vga_pattern_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  function automatic logic [2:0] rgb();
    return {vif.red_out, vif.green_out, vif.blue_out};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int h, input int v, input logic act);
    vif.hcount    = 11'(h);
    vif.vcount    = 10'(v);
    vif.active_in = act;
    cyc();
  endtask

  task automatic do_tick(input logic step);
    vif.active_in = 1'b0;
    vif.vsync_in  = 1'b1;
    vif.mode_step = step;
    cyc();
    vif.vsync_in  = 1'b0;
    vif.mode_step = 1'b0;
    cyc();
    ticks++;
  endtask

  task automatic tick_to(input int n);
    while (ticks < n) do_tick(1'b0);
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    vif.hcount      = '0;
    vif.vcount      = '0;
    vif.active_in   = 1'b0;
    vif.hsync_in    = 1'b0;
    vif.vsync_in    = 1'b0;
    vif.mode_step   = 1'b0;
    vif.force_white = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    ticks = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({rgb(), vif.hsync_out, vif.vsync_out} !== 5'b0) begin
      $display("FAIL reset_outputs: got %b want 00000", {rgb(), vif.hsync_out, vif.vsync_out});
      bad++;
    end
    total++;
    if (vif.mode !== 2'd0) begin
      $display("FAIL reset_mode: got %0d want 0", vif.mode);
      bad++;
    end
  endtask

  task automatic test_bars();
    logic [2:0] exp;
    for (int h = 0; h < 800; h++) begin
      pix(h, 10, 1'b1);
      exp = 3'(h / 100);
      total++;
      if (rgb() !== exp) begin
        $display("FAIL bars h=%0d: got %b want %b", h, rgb(), exp);
        bad++;
      end
    end
    pix(750, 10, 1'b0);
    total++;
    if (rgb() !== 3'b000) begin
      $display("FAIL bars_blank: got %b want 000", rgb());
      bad++;
    end
  endtask

  task automatic test_mode_step();
    vif.mode_step = 1'b1;
    pix(200, 300, 1'b1);
    vif.mode_step = 1'b0;
    pix(201, 300, 1'b1);
    pix(202, 300, 1'b1);
    total++;
    if (vif.mode !== 2'd0) begin
      $display("FAIL step_deferred: got %0d want 0", vif.mode);
      bad++;
    end
    do_tick(1'b0);
    total++;
    if (vif.mode !== 2'd1) begin
      $display("FAIL step_applied: got %0d want 1", vif.mode);
      bad++;
    end
    for (int i = 0; i < 3; i++) begin
      vif.mode_step = 1'b1;
      pix(100 + i, 50, 1'b1);
      vif.mode_step = 1'b0;
      pix(300 + i, 50, 1'b1);
    end
    do_tick(1'b0);
    total++;
    if (vif.mode !== 2'd2) begin
      $display("FAIL step_collapse: got %0d want 2", vif.mode);
      bad++;
    end
    do_tick(1'b0);
    total++;
    if (vif.mode !== 2'd2) begin
      $display("FAIL step_pending_cleared: got %0d want 2", vif.mode);
      bad++;
    end
    do_tick(1'b1);
    total++;
    if (vif.mode !== 2'd3) begin
      $display("FAIL step_coincident: got %0d want 3", vif.mode);
      bad++;
    end
    do_tick(1'b1);
    total++;
    if (vif.mode !== 2'd0) begin
      $display("FAIL step_wrap: got %0d want 0", vif.mode);
      bad++;
    end
    do_tick(1'b1);
  endtask

  task automatic test_checker();
    pix(32, 0, 1'b1);
    total++;
    if (rgb() !== 3'b111) begin
      $display("FAIL checker_32_0: got %b want 111", rgb());
      bad++;
    end
    pix(32, 32, 1'b1);
    total++;
    if (rgb() !== 3'b000) begin
      $display("FAIL checker_32_32: got %b want 000", rgb());
      bad++;
    end
    pix(0, 0, 1'b1);
    total++;
    if (rgb() !== 3'b000) begin
      $display("FAIL checker_0_0: got %b want 000", rgb());
      bad++;
    end
  endtask

  typedef struct { int h; int v; logic [2:0] exp; int after; } box_vec_t;

  task automatic test_box();
    box_vec_t vecs[$];
    do_reset();
    do_tick(1'b1);
    do_tick(1'b1);
    total++;
    if (vif.mode !== 2'd2) begin
      $display("FAIL box_mode: got %0d want 2", vif.mode);
      bad++;
    end
    // Two ticks from reset: box at (8,8).
    vecs.push_back('{8, 8, 3'b111, 2});
    vecs.push_back('{72, 8, 3'b001, 2});
    vecs.push_back('{7, 8, 3'b001, 2});
    vecs.push_back('{71, 71, 3'b111, 2});
    vecs.push_back('{8, 72, 3'b001, 2});
    // Tick 135: y clamped at 536, x=540.
    vecs.push_back('{540, 536, 3'b111, 135});
    vecs.push_back('{540, 599, 3'b111, 135});
    vecs.push_back('{540, 535, 3'b001, 135});
    // Tick 185: x clamped at 736 and reversing, y=336.
    vecs.push_back('{736, 336, 3'b111, 185});
    vecs.push_back('{735, 336, 3'b001, 185});
    vecs.push_back('{799, 399, 3'b111, 185});
    // Tick 186: both axes moving back, box at (732,332).
    vecs.push_back('{732, 332, 3'b111, 186});
    vecs.push_back('{796, 332, 3'b001, 186});
    foreach (vecs[i]) begin
      tick_to(vecs[i].after);
      pix(vecs[i].h, vecs[i].v, 1'b1);
      total++;
      if (rgb() !== vecs[i].exp) begin
        $display("FAIL box t=%0d (%0d,%0d): got %b want %b",
                 ticks, vecs[i].h, vecs[i].v, rgb(), vecs[i].exp);
        bad++;
      end
    end
  endtask

  task automatic test_solid();
    logic [2:0] exp;
    do_reset();
    do_tick(1'b1);
    do_tick(1'b1);
    do_tick(1'b1);
    pix(10, 10, 1'b1);
    total++;
    if (rgb() !== 3'b001 || vif.mode !== 2'd3) begin
      $display("FAIL solid_initial: got rgb=%b mode=%0d want 001 mode=3", rgb(), vif.mode);
      bad++;
    end
    for (int k = 1; k <= 7; k++) begin
      tick_to(64 * k - 1);
      pix(400, 300, 1'b1);
      exp = 3'(k);
      total++;
      if (rgb() !== exp) begin
        $display("FAIL solid_before t=%0d: got %b want %b", ticks, rgb(), exp);
        bad++;
      end
      tick_to(64 * k);
      pix(400, 300, 1'b1);
      exp = 3'((k % 7) + 1);
      total++;
      if (rgb() !== exp) begin
        $display("FAIL solid_after t=%0d: got %b want %b", ticks, rgb(), exp);
        bad++;
      end
    end
  endtask

  task automatic test_force_sync_reset();
    vif.force_white = 1'b1;
    pix(400, 300, 1'b1);
    total++;
    if (rgb() !== 3'b111) begin
      $display("FAIL force_white: got %b want 111", rgb());
      bad++;
    end
    pix(400, 300, 1'b0);
    total++;
    if (rgb() !== 3'b000) begin
      $display("FAIL force_white_blank: got %b want 000", rgb());
      bad++;
    end
    vif.hsync_in = 1'b1;
    vif.vsync_in = 1'b0;
    pix(810, 300, 1'b0);
    total++;
    if ({vif.hsync_out, vif.vsync_out} !== 2'b10) begin
      $display("FAIL sync_h: got %b want 10", {vif.hsync_out, vif.vsync_out});
      bad++;
    end
    vif.hsync_in = 1'b0;
    vif.vsync_in = 1'b1;
    pix(0, 601, 1'b0);
    total++;
    if ({vif.hsync_out, vif.vsync_out} !== 2'b01) begin
      $display("FAIL sync_v: got %b want 01", {vif.hsync_out, vif.vsync_out});
      bad++;
    end
    vif.vsync_in = 1'b0;
    pix(1, 601, 1'b0);
    // Reset mid-line with an active forced-white pixel and hsync asserted.
    vif.hsync_in = 1'b1;
    rst_n = 1'b0;
    pix(300, 200, 1'b1);
    total++;
    if ({rgb(), vif.hsync_out, vif.vsync_out} !== 5'b0 || vif.mode !== 2'd0) begin
      $display("FAIL reset_midline: got outs=%b mode=%0d want 00000 mode=0",
               {rgb(), vif.hsync_out, vif.vsync_out}, vif.mode);
      bad++;
    end
    // vsync already high on the first cycle after reset counts as a tick.
    vif.hsync_in    = 1'b0;
    vif.force_white = 1'b0;
    vif.vsync_in    = 1'b1;
    pix(0, 0, 1'b0);
    rst_n         = 1'b1;
    vif.mode_step = 1'b1;
    pix(0, 0, 1'b0);
    vif.mode_step = 1'b0;
    pix(1, 0, 1'b0);
    total++;
    if (vif.mode !== 2'd1) begin
      $display("FAIL reset_first_tick: got %0d want 1", vif.mode);
      bad++;
    end
    vif.vsync_in = 1'b0;
    pix(2, 0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    ticks = 0;
    test_reset();
    test_bars();
    test_mode_step();
    test_checker();
    test_box();
    test_solid();
    test_force_sync_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
